// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receiver/consumer side and the receive frame FIFO.
interface uart_rx_fifo_if #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] frame;
  logic             frame_valid;
  logic             rd_en;
  logic             flush;
  logic             clr_err;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             level_irq;
  logic             overflow;
  logic             underflow;
  logic [7:0]       drop_cnt;

  // Receiver/consumer side.
  modport master (
    output frame, frame_valid, rd_en, flush, clr_err,
    input  rd_data, rd_valid, count, empty, full, level_irq, overflow, underflow, drop_cnt
  );

  // FIFO side.
  modport slave (
    input  frame, frame_valid, rd_en, flush, clr_err,
    output rd_data, rd_valid, count, empty, full, level_irq, overflow, underflow, drop_cnt
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive frame FIFO: edge-detected pushes from a UART receiver, registered pops,
// sticky overflow/underflow flags and a saturating dropped-frame counter.
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned THRESH = 4
) (
  input logic          clk,
  input logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullLvl   = CW'(DEPTH);
  localparam logic [CW-1:0] ThreshLvl = CW'(THRESH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             fv_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [7:0]       drop_base;

  logic push_evt, push_ok, pop_ok, drop_evt, udf_evt;

  // Event decode and next-state for pointers, fill level and error flags.
  always_comb begin
    push_evt = bus.frame_valid & ~fv_q;
    // A full FIFO can still accept a push when a pop frees the slot in the same cycle.
    pop_ok   = bus.rd_en && (count_q != '0) && !bus.flush;
    push_ok  = push_evt && !bus.flush && ((count_q != FullLvl) || pop_ok);
    drop_evt = push_evt && !bus.flush && (count_q == FullLvl) && !pop_ok;
    udf_evt  = bus.rd_en && (count_q == '0) && !bus.flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Clearing and a new error in the same cycle: the new error wins.
    overflow_d  = (bus.clr_err ? 1'b0 : overflow_q) | drop_evt;
    underflow_d = (bus.clr_err ? 1'b0 : underflow_q) | udf_evt;
    drop_base   = bus.clr_err ? 8'd0 : drop_cnt_q;
    drop_cnt_d  = drop_base;
    if (drop_evt && (drop_base != 8'hFF)) drop_cnt_d = drop_base + 8'd1;
  end

  // Control state; fv_q resets high so a level already present at reset release never pushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      fv_q        <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      fv_q        <= bus.frame_valid;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= pop_ok;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      drop_cnt_q  <= drop_cnt_d;
      if (pop_ok) rd_data_q <= mem[rd_ptr_q];
    end
  end

  // Frame storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr_q] <= bus.frame;
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.count     = count_q;
  assign bus.empty     = (count_q == '0);
  assign bus.full      = (count_q == FullLvl);
  assign bus.level_irq = (count_q >= ThreshLvl);
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with DEPTH=8, WIDTH=9, THRESH=4.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  uart_rx_fifo_if #(.WIDTH(9), .DEPTH(8)) bus ();

  uart_rx_fifo #(.DEPTH(8), .WIDTH(9), .THRESH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.frame_valid = 1'b0;
    bus.rd_en = 1'b0;
    bus.flush = 1'b0;
    bus.clr_err = 1'b0;
    bus.frame = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push(input logic [8:0] v);
    bus.frame = v;
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    tick();
  endtask

  // Pop one frame and check the one-cycle rd_valid pulse and data.
  task automatic pop_check(input string name, input logic [8:0] want);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== want) begin
      bad++;
      $display("FAIL %s pop got valid=%b data=%h want valid=1 data=%h",
               name, bus.rd_valid, bus.rd_data, want);
    end
    tick();
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== want) begin
      bad++;
      $display("FAIL %s hold got valid=%b data=%h want valid=0 data=%h",
               name, bus.rd_valid, bus.rd_data, want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
        bus.level_irq !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 9'h000 ||
        bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_state got cnt=%0d e=%b f=%b irq=%b v=%b d=%h ov=%b un=%b drop=%0d want 0 1 0 0 0 000 0 0 0",
               bus.count, bus.empty, bus.full, bus.level_irq, bus.rd_valid, bus.rd_data,
               bus.overflow, bus.underflow, bus.drop_cnt);
    end
  endtask

  task automatic test_basic();
    logic [8:0] exp [4];
    exp[0] = 9'h101; exp[1] = 9'h102; exp[2] = 9'h103; exp[3] = 9'h104;
    do_reset();
    for (int i = 0; i < 3; i++) push(exp[i]);
    total++;
    if (bus.count !== 4'd3 || bus.level_irq !== 1'b0) begin
      bad++;
      $display("FAIL basic_cnt3 got cnt=%0d irq=%b want cnt=3 irq=0", bus.count, bus.level_irq);
    end
    push(exp[3]);
    total++;
    if (bus.count !== 4'd4 || bus.level_irq !== 1'b1 || bus.empty !== 1'b0) begin
      bad++;
      $display("FAIL basic_cnt4 got cnt=%0d irq=%b empty=%b want cnt=4 irq=1 empty=0",
               bus.count, bus.level_irq, bus.empty);
    end
    for (int i = 0; i < 4; i++) pop_check("basic", exp[i]);
    total++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.underflow !== 1'b0) begin
      bad++;
      $display("FAIL basic_end got cnt=%0d empty=%b un=%b want cnt=0 empty=1 un=0",
               bus.count, bus.empty, bus.underflow);
    end
  endtask

  task automatic test_level_hold();
    do_reset();
    bus.frame = 9'h055;
    bus.frame_valid = 1'b1;
    repeat (10) tick();
    bus.frame_valid = 1'b0;
    tick();
    total++;
    if (bus.count !== 4'd1) begin
      bad++;
      $display("FAIL hold_count got=%0d want=1", bus.count);
    end
    pop_check("hold", 9'h055);
    total++;
    if (bus.empty !== 1'b1) begin
      bad++;
      $display("FAIL hold_empty got=%b want=1", bus.empty);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) push(9'(9'h010 + i));
    total++;
    if (bus.full !== 1'b1 || bus.count !== 4'd8 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_full got full=%b cnt=%0d ov=%b want 1 8 0",
               bus.full, bus.count, bus.overflow);
    end
    for (int i = 0; i < 3; i++) push(9'(9'h0E0 + i));
    total++;
    if (bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd3 || bus.count !== 4'd8) begin
      bad++;
      $display("FAIL ovf_drop got ov=%b drop=%0d cnt=%0d want 1 3 8",
               bus.overflow, bus.drop_cnt, bus.count);
    end
    for (int i = 0; i < 8; i++) pop_check("ovf_order", 9'(9'h010 + i));
    total++;
    if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_end got empty=%b ov=%b want 1 1", bus.empty, bus.overflow);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 8; i++) push(9'(9'h020 + i));
    bus.frame = 9'h1AA;
    bus.frame_valid = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    bus.rd_en = 1'b0;
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 9'h020 || bus.count !== 4'd8 ||
        bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL simul_full got v=%b d=%h cnt=%0d ov=%b want 1 020 8 0",
               bus.rd_valid, bus.rd_data, bus.count, bus.overflow);
    end
    tick();
    for (int i = 1; i < 8; i++) pop_check("simul_order", 9'(9'h020 + i));
    pop_check("simul_last", 9'h1AA);
    bus.frame = 9'h033;
    bus.frame_valid = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    bus.rd_en = 1'b0;
    total++;
    if (bus.underflow !== 1'b1 || bus.rd_valid !== 1'b0 || bus.count !== 4'd1 ||
        bus.rd_data !== 9'h1AA) begin
      bad++;
      $display("FAIL simul_empty got un=%b v=%b cnt=%0d d=%h want 1 0 1 1aa",
               bus.underflow, bus.rd_valid, bus.count, bus.rd_data);
    end
    tick();
    pop_check("simul_nofall", 9'h033);
  endtask

  task automatic test_clr_err();
    do_reset();
    for (int i = 0; i < 8; i++) push(9'(9'h040 + i));
    push(9'h0F1);
    push(9'h0F2);
    total++;
    if (bus.drop_cnt !== 8'd2 || bus.overflow !== 1'b1) begin
      bad++;
      $display("FAIL clr_pre got drop=%0d ov=%b want 2 1", bus.drop_cnt, bus.overflow);
    end
    bus.frame = 9'h0F3;
    bus.frame_valid = 1'b1;
    bus.clr_err = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    bus.clr_err = 1'b0;
    total++;
    if (bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd1) begin
      bad++;
      $display("FAIL clr_race got ov=%b drop=%0d want 1 1", bus.overflow, bus.drop_cnt);
    end
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    total++;
    if (bus.count !== 4'd0 || bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd1) begin
      bad++;
      $display("FAIL clr_flush got cnt=%0d ov=%b drop=%0d want 0 1 1",
               bus.count, bus.overflow, bus.drop_cnt);
    end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    total++;
    if (bus.underflow !== 1'b1 || bus.rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL clr_udf got un=%b v=%b want 1 0", bus.underflow, bus.rd_valid);
    end
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    total++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL clr_all got ov=%b un=%b drop=%0d want 0 0 0",
               bus.overflow, bus.underflow, bus.drop_cnt);
    end
  endtask

  task automatic test_flush_reset();
    do_reset();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    for (int i = 0; i < 5; i++) push(9'(9'h060 + i));
    total++;
    if (bus.count !== 4'd5 || bus.underflow !== 1'b1) begin
      bad++;
      $display("FAIL flush_pre got cnt=%0d un=%b want 5 1", bus.count, bus.underflow);
    end
    bus.flush = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.rd_en = 1'b0;
    total++;
    if (bus.count !== 4'd0 || bus.rd_valid !== 1'b0 || bus.empty !== 1'b1 ||
        bus.underflow !== 1'b1 || bus.overflow !== 1'b0 || bus.rd_data !== 9'h000) begin
      bad++;
      $display("FAIL flush got cnt=%0d v=%b e=%b un=%b ov=%b d=%h want 0 0 1 1 0 000",
               bus.count, bus.rd_valid, bus.empty, bus.underflow, bus.overflow, bus.rd_data);
    end
    // Pointers restart at zero: the next frame pushed is the next one popped.
    push(9'h0A5);
    pop_check("flush_after", 9'h0A5);
    // Reset overrides a same-cycle push.
    push(9'h0B0);
    bus.frame = 9'h0B1;
    bus.frame_valid = 1'b1;
    rst = 1'b1;
    tick();
    total++;
    if (bus.count !== 4'd0 || bus.underflow !== 1'b0 || bus.rd_data !== 9'h000) begin
      bad++;
      $display("FAIL rst_override got cnt=%0d un=%b d=%h want 0 0 000",
               bus.count, bus.underflow, bus.rd_data);
    end
    // frame_valid held high across reset release must not push.
    tick();
    rst = 1'b0;
    tick();
    tick();
    total++;
    if (bus.count !== 4'd0) begin
      bad++;
      $display("FAIL fv_across_rst got cnt=%0d want 0", bus.count);
    end
    bus.frame_valid = 1'b0;
    tick();
    push(9'h0C3);
    total++;
    if (bus.count !== 4'd1) begin
      bad++;
      $display("FAIL post_rst_push got cnt=%0d want 1", bus.count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_level_hold();
    test_overflow();
    test_simultaneous();
    test_clr_err();
    test_flush_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL use a single clock, clk; reset rst is synchronous and active-high.
REQ-002 SHALL have parameter DEPTH, default 8, number of frame entries (power of two).
REQ-003 SHALL have parameter WIDTH, default 9, frame width in bits.
REQ-004 SHALL have parameter THRESH, default 4, fill level at which level_irq asserts.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 frame  input  WIDTH  received frame from the UART receiver.
REQ-008 frame_valid  input  1  frame-ready level from the receiver, synchronous to clk.
REQ-009 rd_en  input  1  consumer pop request.
REQ-010 flush  input  1  discard all stored frames.
REQ-011 clr_err  input  1  clear overflow, underflow and drop_cnt.
REQ-012 rd_data  output  WIDTH  popped frame.
REQ-013 rd_valid  output  1  one-cycle pulse; rd_data is valid.
REQ-014 count  output  log2(DEPTH)+1  current fill level.
REQ-015 empty / full  output  1 each  count==0 / count==DEPTH.
REQ-016 level_irq  output  1  count >= THRESH.
REQ-017 overflow / underflow  output  1 each  sticky error flags.
REQ-018 drop_cnt  output  8  saturating count of dropped frames.

Function
REQ-019 SHALL form push_evt = frame_valid & ~fv_q, fv_q being frame_valid registered; a level held for many cycles SHALL push exactly once.
REQ-020 push_evt with count<DEPTH (or with a same-cycle accepted pop) SHALL write frame to mem[wr_ptr] and advance wr_ptr modulo DEPTH.
REQ-021 push_evt when full without an accepted pop SHALL drop the frame, set overflow, and increment drop_cnt, saturating at 255.
REQ-022 rd_en with count>0 SHALL register rd_data <= mem[rd_ptr], pulse rd_valid the next cycle, and advance rd_ptr modulo DEPTH; read latency is 1 cycle.
REQ-023 rd_en with count==0 SHALL be ignored, set underflow, leave rd_valid low and hold rd_data; there is no fall-through, even with a same-cycle push.
REQ-024 rd_data SHALL hold its last value between pops.
REQ-025 Push and pop in the same cycle when 0<count<=DEPTH SHALL both succeed, with count unchanged.
REQ-026 count SHALL change by +1 on push only, -1 on pop only, and 0 otherwise; pointers wrap without affecting count.
REQ-027 empty, full and level_irq SHALL be combinational decodes of registered count.
REQ-028 flush SHALL zero wr_ptr, rd_ptr and count next cycle, suppressing that cycle's push and pop (no rd_valid), and SHALL leave the error flags untouched.
REQ-029 clr_err SHALL zero overflow, underflow and drop_cnt; a new error event in the same cycle wins (flag set, drop_cnt=1).
REQ-030 Memory contents SHALL NOT be reset; only pointers, count, flags and outputs are reset.

Reset
REQ-031 On rst: wr_ptr=rd_ptr=count=0, empty=1, full=0, level_irq=0, rd_valid=0, rd_data=0, overflow=underflow=0, drop_cnt=0.
REQ-032 Reset SHALL set fv_q=1, so a frame_valid held high through reset release does not push.
REQ-033 rst SHALL override flush, clr_err, push and pop in the same cycle, including mid-operation.

Verification
REQ-034 Push frames 0x101..0x104 (one frame_valid pulse each), then 4 rd_en pulses -> rd_data 0x101,0x102,0x103,0x104 each with a one-cycle rd_valid a cycle after rd_en; level_irq=1 at count=4; empty=1 at end.
REQ-035 Hold frame_valid high 10 cycles with frame=0x055 -> count=1, a single entry.
REQ-036 Fill 8 frames, push 3 more -> full=1, overflow=1, drop_cnt=3, and popping 8 frames returns the original 8 in order.
REQ-037 At count=8, push 0x1AA with rd_en in the same cycle -> count stays 8, no overflow, 0x1AA returned last; with count=0, rd_en plus push -> underflow=1, no rd_valid, count=1.
REQ-038 Drive clr_err on the same cycle as a push when full -> overflow=1, drop_cnt=1; then clr_err alone -> all cleared.
REQ-039 At count=5, assert flush together with rd_en -> count=0, no rd_valid, flags unchanged; with frame_valid high across rst deassert -> no push.
